tm_core_param: RTL and testbench

Parametrised Turing-machine core and next-generation successor to the fixed-format 1-bit-tape machine. Symbol width, state count and tape length are configurable, and the rule table and tape are held in internal registers. The rule table and tape are loaded through dedicated write ports, then the machine runs either free-running or single-stepped. It reports halt, head-out-of-range fault, step count and an optional step-limit timeout, and sits under the board-level controller that drives load, run and observe.

---
 rtl/tm_core_param.sv | 163 ++++++++++++++++
 tb/tb_tm_core_param.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_core_param.sv
// Parametrised Turing-machine core: internal rule table and tape, load ports, free-run/step modes.
// Optional step-limit timeout is compiled in when TM_STEP_LIMIT_EN is defined.
module tm_core_param #(
  parameter int unsigned SW = 2,
  parameter int unsigned NS = 8,
  parameter int unsigned TL = 32,
  parameter int unsigned CW = 16,
  localparam int unsigned SAW = $clog2(NS),
  localparam int unsigned TAW = $clog2(TL)
) (
  input  logic           clock,
  input  logic           Reset_n,
  input  logic           rule_we,
  input  logic [SAW-1:0] rule_state,
  input  logic [SW-1:0]  rule_sym,
  input  logic [SW-1:0]  rule_wsym,
  input  logic [1:0]     rule_dir,
  input  logic [SAW-1:0] rule_next,
  input  logic           rule_halt,
  input  logic           tape_we,
  input  logic [TAW-1:0] tape_addr,
  input  logic [SW-1:0]  tape_wdata,
  output logic [SW-1:0]  tape_rdata,
  input  logic           start,
  input  logic [TAW-1:0] start_pos,
  input  logic           step_mode,
  input  logic           step,
  input  logic [CW-1:0]  step_limit,
  output logic           busy,
  output logic           halted,
  output logic           fault,
  output logic           timeout,
  output logic [SAW-1:0] cur_state,
  output logic [TAW-1:0] head_pos,
  output logic [CW-1:0]  step_count
);

  localparam int unsigned RW = 1 + SAW + 2 + SW;
  localparam int unsigned RN = 2 ** (SAW + SW);

  typedef struct packed {
    logic           halt;
    logic [SAW-1:0] nxt;
    logic [1:0]     dir;
    logic [SW-1:0]  wsym;
  } rule_t;

  // Unprogrammed entries halt.
  localparam rule_t RuleReset = rule_t'({1'b1, {(RW - 1){1'b0}}});

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StPause,
    StHalt,
    StFault
  } state_e;

  state_e        state;
  rule_t         rules [RN];
  logic [SW-1:0] tape [TL];
  rule_t         rule_q;

  rule_t         fetched;
  rule_t         rule_wr;
  logic          move_left;
  logic          move_right;
  logic          edge_fault;
  logic [CW-1:0] cnt_inc;
  logic          limit_hit;

  assign tape_rdata = tape[tape_addr];
  assign fetched    = rules[{cur_state, tape[head_pos]}];
  assign rule_wr    = '{halt: rule_halt, nxt: rule_next, dir: rule_dir, wsym: rule_wsym};

  always_comb begin
    move_right = (rule_q.dir == 2'b01);
    move_left  = (rule_q.dir == 2'b10);
    edge_fault = (move_left && (head_pos == '0)) ||
                 (move_right && (head_pos == TAW'(TL - 1)));
    cnt_inc    = (step_count == '1) ? step_count : step_count + CW'(1);
  end

`ifdef TM_STEP_LIMIT_EN
  assign limit_hit = (step_limit != '0) && (cnt_inc == step_limit);
`else
  logic unused_step_limit;
  assign unused_step_limit = ^step_limit;
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= StIdle;
      rules      <= '{default: RuleReset};
      tape       <= '{default: '0};
      rule_q     <= RuleReset;
      busy       <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      timeout    <= 1'b0;
      cur_state  <= '0;
      head_pos   <= '0;
      step_count <= '0;
    end else begin
      unique case (state)
        StIdle, StHalt, StFault: begin
          if (rule_we) rules[{rule_state, rule_sym}] <= rule_wr;
          if (tape_we) tape[tape_addr] <= tape_wdata;
          if (start) begin
            state      <= StFetch;
            cur_state  <= '0;
            head_pos   <= start_pos;
            step_count <= '0;
            busy       <= 1'b1;
            halted     <= 1'b0;
            fault      <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        StFetch: begin
          rule_q <= fetched;
          if (fetched.halt) begin
            state  <= StHalt;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= StExec;
          end
        end
        StExec: begin
          tape[head_pos] <= rule_q.wsym;
          cur_state      <= rule_q.nxt;
          step_count     <= cnt_inc;
          if (edge_fault) begin
            state <= StFault;
            busy  <= 1'b0;
            fault <= 1'b1;
          end else begin
            if (move_right) head_pos <= head_pos + TAW'(1);
            else if (move_left) head_pos <= head_pos - TAW'(1);
            if (limit_hit) begin
              state   <= StHalt;
              busy    <= 1'b0;
              halted  <= 1'b1;
              timeout <= 1'b1;
            end else if (step_mode) begin
              state <= StPause;
            end else begin
              state <= StFetch;
            end
          end
        end
        StPause: begin
          if (step || !step_mode) state <= StFetch;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tm_core_param.sv
// Directed self-checking bench for tm_core_param (default parameters).
// Timeout expectations follow TM_STEP_LIMIT_EN as defined for the build.
module tb_tm_core_param;

  logic        clock;
  logic        Reset_n;
  logic        rule_we;
  logic [2:0]  rule_state;
  logic [1:0]  rule_sym;
  logic [1:0]  rule_wsym;
  logic [1:0]  rule_dir;
  logic [2:0]  rule_next;
  logic        rule_halt;
  logic        tape_we;
  logic [4:0]  tape_addr;
  logic [1:0]  tape_wdata;
  logic [1:0]  tape_rdata;
  logic        start;
  logic [4:0]  start_pos;
  logic        step_mode;
  logic        step;
  logic [15:0] step_limit;
  logic        busy;
  logic        halted;
  logic        fault;
  logic        timeout;
  logic [2:0]  cur_state;
  logic [4:0]  head_pos;
  logic [15:0] step_count;

  int vectors = 0;
  int miscompares = 0;

  tm_core_param dut (
    .clock      (clock),
    .Reset_n    (Reset_n),
    .rule_we    (rule_we),
    .rule_state (rule_state),
    .rule_sym   (rule_sym),
    .rule_wsym  (rule_wsym),
    .rule_dir   (rule_dir),
    .rule_next  (rule_next),
    .rule_halt  (rule_halt),
    .tape_we    (tape_we),
    .tape_addr  (tape_addr),
    .tape_wdata (tape_wdata),
    .tape_rdata (tape_rdata),
    .start      (start),
    .start_pos  (start_pos),
    .step_mode  (step_mode),
    .step       (step),
    .step_limit (step_limit),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .timeout    (timeout),
    .cur_state  (cur_state),
    .head_pos   (head_pos),
    .step_count (step_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // All stimulus tasks leave time at 1 ns after a rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    tick(2);
    Reset_n = 1'b1;
    tick(1);
  endtask

  task automatic write_rule(input logic [2:0] st, input logic [1:0] sym, input logic [1:0] ws,
                            input logic [1:0] dir, input logic [2:0] nx, input logic hlt);
    rule_we = 1'b1; rule_state = st; rule_sym = sym;
    rule_wsym = ws; rule_dir = dir; rule_next = nx; rule_halt = hlt;
    tick(1);
    rule_we = 1'b0;
  endtask

  task automatic write_tape(input logic [4:0] a, input logic [1:0] d);
    tape_we = 1'b1; tape_addr = a; tape_wdata = d;
    tick(1);
    tape_we = 1'b0;
  endtask

  // Ends just after edge E where start was sampled.
  task automatic do_start(input logic [4:0] pos);
    start = 1'b1; start_pos = pos;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tape_addr = 5'd5; #1;
    vectors++;
    if ({busy, halted, fault, timeout} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b want 0000", {busy, halted, fault, timeout});
    end
    vectors++;
    if ({cur_state, head_pos, step_count} !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_regs: got st=%0d hp=%0d sc=%0d want 0", cur_state, head_pos, step_count);
    end
    vectors++;
    if (tape_rdata !== 2'd0) begin
      miscompares++; $display("FAIL reset_tape: got %0d want 0", tape_rdata);
    end
  endtask

  task automatic test_unary_scan();
    write_rule(3'd0, 2'd0, 2'd1, 2'b01, 3'd0, 1'b0);
    write_tape(5'd3, 2'd1);
    tape_addr = 5'd3; #1;
    vectors++;
    if (tape_rdata !== 2'd1) begin
      miscompares++; $display("FAIL tape_readback: got %0d want 1", tape_rdata);
    end
    do_start(5'd0);
    tick(6);
    vectors++;
    if (busy !== 1'b1 || halted !== 1'b0) begin
      miscompares++; $display("FAIL scan_e6: got busy=%b halted=%b want 1 0", busy, halted);
    end
    tick(1);
    vectors++;
    if (halted !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL scan_e7: got busy=%b halted=%b want 0 1", busy, halted);
    end
    vectors++;
    if (head_pos !== 5'd3 || step_count !== 16'd3 || cur_state !== 3'd0) begin
      miscompares++;
      $display("FAIL scan_regs: got hp=%0d sc=%0d st=%0d want 3 3 0", head_pos, step_count, cur_state);
    end
    for (int c = 0; c < 4; c++) begin
      tape_addr = 5'(c); #1;
      vectors++;
      if (tape_rdata !== 2'd1) begin
        miscompares++; $display("FAIL scan_cell%0d: got %0d want 1", c, tape_rdata);
      end
    end
  endtask

  task automatic test_restart();
    do_start(5'd2);
    vectors++;
    if (busy !== 1'b1 || halted !== 1'b0 || step_count !== 16'd0 || head_pos !== 5'd2) begin
      miscompares++;
      $display("FAIL restart_start: got busy=%b halted=%b sc=%0d hp=%0d want 1 0 0 2",
               busy, halted, step_count, head_pos);
    end
    tick(1);
    vectors++;
    if (halted !== 1'b1 || step_count !== 16'd0 || head_pos !== 5'd2) begin
      miscompares++;
      $display("FAIL restart_halt: got halted=%b sc=%0d hp=%0d want 1 0 2",
               halted, step_count, head_pos);
    end
  endtask

  task automatic test_fault();
    do_reset();
    write_rule(3'd0, 2'd0, 2'd2, 2'b10, 3'd1, 1'b0);
    do_start(5'd0);
    tick(1);
    vectors++;
    if (busy !== 1'b1 || fault !== 1'b0) begin
      miscompares++; $display("FAIL fault_e1: got busy=%b fault=%b want 1 0", busy, fault);
    end
    tick(1);
    tape_addr = 5'd0; #1;
    vectors++;
    if (fault !== 1'b1 || busy !== 1'b0 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_left: got fault=%b busy=%b halted=%b want 1 0 0", fault, busy, halted);
    end
    vectors++;
    if (tape_rdata !== 2'd2 || head_pos !== 5'd0 || cur_state !== 3'd1 || step_count !== 16'd1) begin
      miscompares++;
      $display("FAIL fault_left_regs: got cell=%0d hp=%0d st=%0d sc=%0d want 2 0 1 1",
               tape_rdata, head_pos, cur_state, step_count);
    end
    // Right edge: rule load accepted in FAULT, then run from the last cell.
    write_rule(3'd0, 2'd0, 2'd1, 2'b01, 3'd2, 1'b0);
    do_start(5'd31);
    vectors++;
    if (fault !== 1'b0) begin
      miscompares++; $display("FAIL fault_clear: got %b want 0", fault);
    end
    tick(2);
    tape_addr = 5'd31; #1;
    vectors++;
    if (fault !== 1'b1 || head_pos !== 5'd31 || tape_rdata !== 2'd1 || cur_state !== 3'd2) begin
      miscompares++;
      $display("FAIL fault_right: got fault=%b hp=%0d cell=%0d st=%0d want 1 31 1 2",
               fault, head_pos, tape_rdata, cur_state);
    end
  endtask

  task automatic test_step_mode();
    do_reset();
    write_rule(3'd0, 2'd0, 2'd1, 2'b01, 3'd0, 1'b0);
    write_tape(5'd3, 2'd1);
    step_mode = 1'b1;
    do_start(5'd0);
    tick(5);
    vectors++;
    if (busy !== 1'b1 || step_count !== 16'd1 || head_pos !== 5'd1) begin
      miscompares++;
      $display("FAIL pause_first: got busy=%b sc=%0d hp=%0d want 1 1 1", busy, step_count, head_pos);
    end
    pulse_step();
    tick(1);
    vectors++;
    if (step_count !== 16'd1) begin
      miscompares++; $display("FAIL step_p1: got sc=%0d want 1", step_count);
    end
    tick(1);
    vectors++;
    if (step_count !== 16'd2 || head_pos !== 5'd2) begin
      miscompares++; $display("FAIL step_p2: got sc=%0d hp=%0d want 2 2", step_count, head_pos);
    end
    tick(4);
    vectors++;
    if (step_count !== 16'd2 || busy !== 1'b1) begin
      miscompares++; $display("FAIL step_hold: got sc=%0d busy=%b want 2 1", step_count, busy);
    end
    pulse_step();
    tick(2);
    vectors++;
    if (step_count !== 16'd3 || head_pos !== 5'd3 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL step_2nd: got sc=%0d hp=%0d busy=%b want 3 3 1", step_count, head_pos, busy);
    end
    pulse_step();
    tick(1);
    vectors++;
    if (halted !== 1'b1 || step_count !== 16'd3) begin
      miscompares++; $display("FAIL step_halt: got halted=%b sc=%0d want 1 3", halted, step_count);
    end
    pulse_step();
    tick(2);
    vectors++;
    if (halted !== 1'b1 || busy !== 1'b0 || step_count !== 16'd3) begin
      miscompares++;
      $display("FAIL step_after_halt: got halted=%b busy=%b sc=%0d want 1 0 3",
               halted, busy, step_count);
    end
    step_mode = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    write_rule(3'd0, 2'd0, 2'd0, 2'b00, 3'd0, 1'b0);
    step_limit = 16'd5;
    do_start(5'd4);
    tick(9);
    vectors++;
    if (busy !== 1'b1 || step_count !== 16'd4) begin
      miscompares++; $display("FAIL limit_e9: got busy=%b sc=%0d want 1 4", busy, step_count);
    end
    tick(1);
`ifdef TM_STEP_LIMIT_EN
    vectors++;
    if (halted !== 1'b1 || timeout !== 1'b1 || step_count !== 16'd5 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL limit_hit: got halted=%b timeout=%b sc=%0d busy=%b want 1 1 5 0",
               halted, timeout, step_count, busy);
    end
`else
    vectors++;
    if (busy !== 1'b1 || timeout !== 1'b0 || step_count !== 16'd5) begin
      miscompares++;
      $display("FAIL limit_off: got busy=%b timeout=%b sc=%0d want 1 0 5", busy, timeout, step_count);
    end
    tick(10);
    vectors++;
    if (busy !== 1'b1 || step_count !== 16'd10) begin
      miscompares++; $display("FAIL limit_off_run: got busy=%b sc=%0d want 1 10", busy, step_count);
    end
`endif
    step_limit = 16'd0;
  endtask

  task automatic test_lockout_reset();
    do_reset();
    write_tape(5'd4, 2'd2);
    write_rule(3'd0, 2'd0, 2'd0, 2'b00, 3'd3, 1'b0);
    write_rule(3'd3, 2'd0, 2'd0, 2'b00, 3'd3, 1'b0);
    do_start(5'd5);
    tick(3);
    // Writes while busy must be dropped: the halt rule would end the loop.
    tape_we = 1'b1; tape_addr = 5'd7; tape_wdata = 2'd3;
    rule_we = 1'b1; rule_state = 3'd3; rule_sym = 2'd0; rule_halt = 1'b1;
    rule_wsym = 2'd0; rule_dir = 2'b00; rule_next = 3'd0;
    tick(1);
    tape_we = 1'b0; rule_we = 1'b0;
    tick(4);
    tape_addr = 5'd7; #1;
    vectors++;
    if (tape_rdata !== 2'd0) begin
      miscompares++; $display("FAIL lockout_tape: got %0d want 0", tape_rdata);
    end
    vectors++;
    if (busy !== 1'b1 || cur_state !== 3'd3 || head_pos !== 5'd5) begin
      miscompares++;
      $display("FAIL lockout_rule: got busy=%b st=%0d hp=%0d want 1 3 5", busy, cur_state, head_pos);
    end
    Reset_n = 1'b0;
    tape_addr = 5'd4; #2;
    vectors++;
    if ({busy, halted, fault, timeout} !== 4'b0000 ||
        {cur_state, head_pos, step_count} !== 24'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: got flags=%b st=%0d hp=%0d sc=%0d want 0",
               {busy, halted, fault, timeout}, cur_state, head_pos, step_count);
    end
    vectors++;
    if (tape_rdata !== 2'd0) begin
      miscompares++; $display("FAIL midrun_reset_tape: got %0d want 0", tape_rdata);
    end
    tick(1);
    Reset_n = 1'b1;
    tick(1);
    do_start(5'd0);
    tick(1);
    vectors++;
    if (halted !== 1'b1 || step_count !== 16'd0 || cur_state !== 3'd0) begin
      miscompares++;
      $display("FAIL default_rule_halt: got halted=%b sc=%0d st=%0d want 1 0 0",
               halted, step_count, cur_state);
    end
  endtask

  initial begin
    Reset_n = 1'b0; rule_we = 1'b0; rule_state = '0; rule_sym = '0; rule_wsym = '0;
    rule_dir = '0; rule_next = '0; rule_halt = 1'b0; tape_we = 1'b0; tape_addr = '0;
    tape_wdata = '0; start = 1'b0; start_pos = '0; step_mode = 1'b0; step = 1'b0;
    step_limit = '0;
    #1;
    test_reset();
    test_unary_scan();
    test_restart();
    test_fault();
    test_step_mode();
    test_timeout();
    test_lockout_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
